// File: rtl/apb_completer_regfile.sv
// Purpose: APB4 completer holding NUM_REGS registers (reg 0 read-only ID) with byte-lane writes and PSLVERR.
// Latency: setup cycle plus WAIT_STATES+1 access cycles; regs_o updates on the completion edge.
// Backpressure: PREADY is held low for WAIT_STATES access cycles; dropping PSEL mid-access aborts the transfer.
module apb_completer_regfile #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 'hA9B0_0001
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = ADDR_WIDTH - 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           strb_q;
    logic [3:0]              wait_cnt;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic [IW-1:0]           idx;
    logic [31:0]             idx_w;
    logic                    dec_err;
    logic                    setup;
    logic [DATA_WIDTH-1:0]   rd_sel;

    // Decode runs on the captured address so PADDR wiggles during wait states are harmless.
    assign idx     = addr_q[ADDR_WIDTH-1:2];
    assign idx_w   = 32'(idx);
    assign dec_err = (idx_w >= 32'(NUM_REGS)) || (addr_q[1:0] != 2'b00) || (write_q && (idx_w == 32'd0));
    assign setup   = (state_q == IDLE) && PSEL && !PENABLE;

    // FSM state register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake: completion when the wait counter has drained and the master is in access.
    always_comb begin
        state_d = state_q;
        PREADY  = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                PREADY = (wait_cnt == 4'd0) && PSEL && PENABLE;
                if (!PSEL || PREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the setup-phase controls, run the wait counter and apply byte-lane writes on completion.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            wait_cnt <= 4'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == 0) ? ID_VALUE : '0;
            end
        end else begin
            if (setup) begin
                addr_q   <= PADDR;
                write_q  <= PWRITE;
                wdata_q  <= PWDATA;
                strb_q   <= PSTRB;
                wait_cnt <= 4'(WAIT_STATES);
            end else if ((state_q == ACCESS) && PSEL && PENABLE && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (PREADY && write_q && !dec_err) begin
                // Reg 0 is never a legal write target, so the loop starts at 1.
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (idx_w == 32'(i)) begin
                        for (int b = 0; b < NB; b++) begin
                            if (strb_q[b]) begin
                                regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Read mux; out-of-range indices fall through to zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_w == 32'(i)) begin
                rd_sel = regs[i];
            end
        end
    end

    // Response outputs: data only on a good read completion, error only alongside PREADY.
    always_comb begin
        PRDATA  = (PREADY && !write_q && !dec_err) ? rd_sel : '0;
        PSLVERR = PREADY && dec_err;
    end

    // Flatten the register bank for downstream logic, reg 0 in the LSBs.
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Purpose: self-checking bench for apb_completer_regfile against a transaction-level register model.
// Latency: expects a setup cycle, WAIT_STATES low access cycles, then one PREADY cycle.
// Backpressure: exercises wait states, aborts, reset mid-access and back-to-back transfers.
module tb_apb_completer_regfile;

    localparam int          AW = 8;
    localparam int          DW = 32;
    localparam int          NR = 16;
    localparam int          WS = 1;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic              clk = 1'b0;
    logic              PRESET;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [DW/8-1:0]   PSTRB;
    logic [DW-1:0]     PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [NR*DW-1:0]  regs_o;

    apb_completer_regfile #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .WAIT_STATES(WS),
        .ID_VALUE   (ID)
    ) dut (
        .PCLK   (clk),
        .PRESET (PRESET),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PSTRB  (PSTRB),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR),
        .regs_o (regs_o)
    );

    always #5 clk = ~clk;

    // Register model and per-cycle expectations.
    logic [31:0] model [NR];
    logic        exp_rdy;
    logic        exp_err;
    logic [31:0] exp_rdata;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = (i == 0) ? ID : 32'h0;
    endtask

    // Every-cycle compare of the handshake, response and exported registers.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("pready", 64'(PREADY), 64'(exp_rdy));
            chk("pslverr", 64'(PSLVERR), exp_rdy ? 64'(exp_err) : 64'd0);
            chk("prdata", 64'(PRDATA), exp_rdy ? 64'(exp_rdata) : 64'd0);
            checks++;
            if (regs_o !== model_flat()) begin
                failures++;
                $display("FAIL regs_o: got %h expected %h", regs_o, model_flat());
            end
        end
    end

    task automatic set_idle();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        exp_rdy = 1'b0; exp_err = 1'b0; exp_rdata = '0;
    endtask

    task automatic idle(input int n);
        set_idle();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One full transfer, entered at posedge+1; returns without idling so calls can be back-to-back.
    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rd, output logic err_o,
                        output int low_cycles);
        int          idx;
        bit          err;
        logic [31:0] expd;
        idx  = int'(addr[7:2]);
        err  = (idx >= NR) || (addr[1:0] != 2'b00) || (wr && idx == 0);
        expd = (err || wr) ? 32'h0 : model[idx];
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
        exp_rdy = 1'b0; exp_err = 1'b0; exp_rdata = '0;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        PADDR   = ~addr;
        low_cycles = 0;
        rd = 'x; err_o = 1'bx;
        for (int k = 0; k <= WS; k++) begin
            if (k == WS) begin
                exp_rdy = 1'b1; exp_err = err; exp_rdata = expd;
            end
            @(negedge clk);
            if (!PREADY) low_cycles++;
            if (k == WS) begin
                rd = PRDATA; err_o = PSLVERR;
            end
            @(posedge clk); #1;
        end
        if (wr && !err) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        set_idle();
    endtask

    logic [31:0] rd;
    logic        err;
    int          lows;

    initial begin
        set_idle();
        model_reset();
        // Reset for two cycles.
        PRESET = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        PRESET = 1'b0;
        chk("reset_reg0_flat", 64'(regs_o[31:0]), 64'(32'hA9B0_0001));
        xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, err, lows);
        chk("reset_reg0_read", 64'(rd), 64'(32'hA9B0_0001));
        idle(1);

        // Full write with one wait state, then read back.
        xfer(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, err, lows);
        chk("wr04_low_cycles", 64'(lows), 64'd1);
        chk("wr04_err", 64'(err), 64'd0);
        idle(1);
        xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, err, lows);
        chk("rd04_data", 64'(rd), 64'(32'hDEADBEEF));
        chk("rd04_err", 64'(err), 64'd0);
        idle(1);

        // Partial-strobe write over zero.
        xfer(1'b1, 8'h08, 32'h11223344, 4'b0101, rd, err, lows);
        xfer(1'b0, 8'h08, 32'hFFFFFFFF, 4'hF, rd, err, lows);
        chk("rd08_strobe", 64'(rd), 64'(32'h00220044));
        idle(2);

        // Error cases: out of range, read-only reg 0, misaligned.
        xfer(1'b0, 8'h40, 32'h0, 4'h0, rd, err, lows);
        chk("rd40_err", 64'(err), 64'd1);
        chk("rd40_data", 64'(rd), 64'd0);
        xfer(1'b1, 8'h00, 32'hFFFFFFFF, 4'hF, rd, err, lows);
        chk("wr00_err", 64'(err), 64'd1);
        xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, err, lows);
        chk("rd00_after_err", 64'(rd), 64'(32'hA9B0_0001));
        xfer(1'b1, 8'h06, 32'h12345678, 4'hF, rd, err, lows);
        chk("wr06_misaligned_err", 64'(err), 64'd1);
        chk("reg1_untouched", 64'(regs_o[63:32]), 64'(32'hDEADBEEF));

        // Zero-strobe write is legal and changes nothing; last register is reachable.
        xfer(1'b1, 8'h04, 32'h00000000, 4'h0, rd, err, lows);
        chk("wr04_nostrb_err", 64'(err), 64'd0);
        xfer(1'b1, 8'h3C, 32'h89ABCDEF, 4'hF, rd, err, lows);
        xfer(1'b0, 8'h3C, 32'h0, 4'h0, rd, err, lows);
        chk("rd3c_data", 64'(rd), 64'(32'h89ABCDEF));
        chk("reg1_after_nostrb", 64'(regs_o[63:32]), 64'(32'hDEADBEEF));

        // Back-to-back write then read, no idle in between.
        xfer(1'b1, 8'h0C, 32'hCAFEF00D, 4'hF, rd, err, lows);
        xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, lows);
        chk("b2b_rd0c", 64'(rd), 64'(32'hCAFEF00D));
        idle(1);

        // Enable without a setup phase is ignored.
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = 8'h04;
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle(1);

        // Abort: PSEL dropped during the wait of a write to 0x10.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'h55AA55AA; PSTRB = 4'hF;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        set_idle();
        @(posedge clk); #1;
        // If the abort were missed, this enable would complete the stale write.
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'h55AA55AA; PSTRB = 4'hF;
        @(posedge clk); #1;
        idle(1);
        chk("abort_reg10", 64'(regs_o[4*DW +: DW]), 64'd0);

        // Reset in the middle of an access, with the master still driving access.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'h77777777; PSTRB = 4'hF;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        PRESET  = 1'b1;
        @(posedge clk); #1;
        model_reset();
        @(posedge clk); #1;
        PRESET = 1'b0;
        @(posedge clk); #1;
        idle(1);
        chk("rst_reg10", 64'(regs_o[4*DW +: DW]), 64'd0);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, rd, err, lows);
        chk("rst_rd10", 64'(rd), 64'd0);
        xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, err, lows);
        chk("rst_rd04", 64'(rd), 64'd0);
        xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, err, lows);
        chk("rst_rd00", 64'(rd), 64'(32'hA9B0_0001));
        idle(2);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
